// File: rtl/icache.sv
// ============================================================================
// Module   : icache
// Brief    : Direct-mapped, one-word-per-block instruction cache with a
//            same-cycle hit path and a REN/wait fill from memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache #(
  parameter int ICACHE_SETS     = 16,
  parameter int LOG_ICACHE_SETS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        icache_REN,
  input  logic [31:0] icache_addr,
  input  logic        icache_halt,
  output logic        icache_hit,
  output logic [31:0] icache_load,
  output logic        imem_REN,
  output logic [31:0] imem_addr,
  input  logic        imem_wait,
  input  logic [31:0] imem_load,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
);

  localparam int TAG_W = 32 - LOG_ICACHE_SETS - 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MISS = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [ICACHE_SETS-1:0]     valid_q;
  logic [TAG_W-1:0]           tag_q  [ICACHE_SETS];
  logic [31:0]                data_q [ICACHE_SETS];
  logic [31:0]                miss_addr_q;
  logic [31:0]                perf_hits_q, perf_hits_d;
  logic [31:0]                perf_misses_q, perf_misses_d;

  logic [LOG_ICACHE_SETS-1:0] req_idx, miss_idx;
  logic [TAG_W-1:0]           req_tag, miss_tag;
  logic                       lookup_hit;
  logic                       hit_w;
  logic                       miss_en;
  logic                       fill_en;

  assign req_idx    = icache_addr[LOG_ICACHE_SETS+1:2];
  assign req_tag    = icache_addr[31:LOG_ICACHE_SETS+2];
  assign miss_idx   = miss_addr_q[LOG_ICACHE_SETS+1:2];
  assign miss_tag   = miss_addr_q[31:LOG_ICACHE_SETS+2];
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign hit_w   = (state_q == S_IDLE) && icache_REN && !icache_halt && lookup_hit;
  assign miss_en = (state_q == S_IDLE) && icache_REN && !icache_halt && !lookup_hit;
  // Halt outranks a fill returning on the same edge: the word is dropped.
  assign fill_en = (state_q == S_MISS) && !imem_wait && !icache_halt;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (icache_halt) begin
      state_d = S_HALT;
    end else begin
      case (state_q)
        S_IDLE:  if (miss_en)    state_d = S_MISS;
        S_MISS:  if (!imem_wait) state_d = S_IDLE;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    icache_hit  = hit_w;
    icache_load = hit_w ? data_q[req_idx] : 32'h0;
    imem_REN    = (state_q == S_MISS);
    imem_addr   = miss_addr_q & 32'hFFFF_FFFC;
    perf_hits   = perf_hits_q;
    perf_misses = perf_misses_q;
  end

  always_comb begin
    perf_hits_d   = perf_hits_q;
    perf_misses_d = perf_misses_q;
    if (hit_w)   perf_hits_d   = perf_hits_q + 32'd1;
    if (miss_en) perf_misses_d = perf_misses_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q       <= '0;
      miss_addr_q   <= '0;
      perf_hits_q   <= '0;
      perf_misses_q <= '0;
    end else begin
      perf_hits_q   <= perf_hits_d;
      perf_misses_q <= perf_misses_d;
      if (miss_en) miss_addr_q <= icache_addr;
      if (fill_en) valid_q[miss_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset; valid gates every use of them.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= imem_load;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
// Module   : tb_icache
// Brief    : Self-checking bench for icache: directed vector table, corner
//            sequences and randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache;

  localparam int SETS = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        icache_REN;
  logic [31:0] icache_addr;
  logic        icache_halt;
  logic        icache_hit;
  logic [31:0] icache_load;
  logic        imem_REN;
  logic [31:0] imem_addr;
  logic        imem_wait;
  logic [31:0] imem_load;
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;

  always #5 CLK = ~CLK;

  icache #(.ICACHE_SETS(SETS), .LOG_ICACHE_SETS(4)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .icache_REN  (icache_REN),
    .icache_addr (icache_addr),
    .icache_halt (icache_halt),
    .icache_hit  (icache_hit),
    .icache_load (icache_load),
    .imem_REN    (imem_REN),
    .imem_addr   (imem_addr),
    .imem_wait   (imem_wait),
    .imem_load   (imem_load),
    .perf_hits   (perf_hits),
    .perf_misses (perf_misses)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: each set remembers which word address it holds.
  bit          m_valid [SETS];
  logic [29:0] m_word  [SETS];
  logic [31:0] m_data  [SETS];
  bit          m_in_miss;
  bit          m_halted;
  logic [31:0] m_miss_addr;
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        wt;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_imem_ren;
    logic [31:0] e_imem_addr;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 2) % 32'(SETS));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) m_valid[i] = 0;
    m_in_miss   = 0;
    m_halted    = 0;
    m_miss_addr = 32'h0;
    m_hits      = 32'h0;
    m_misses    = 32'h0;
  endtask

  // Drives one cycle, checks all outputs against the model, then advances the
  // model with the rules for the coming edge.
  task automatic cycle(input logic rst, input logic ren, input logic [31:0] addr,
                       input logic halt, input logic wt, input logic [31:0] ld);
    logic        ehit;
    logic [31:0] eload;
    int          s;
    int          ms;
    RST = rst; icache_REN = ren; icache_addr = addr; icache_halt = halt;
    imem_wait = wt; imem_load = ld;
    #1;
    s     = set_of(addr);
    ehit  = !m_halted && !m_in_miss && ren && !halt && m_valid[s] && (m_word[s] == addr[31:2]);
    eload = ehit ? m_data[s] : 32'h0;
    check("hit", {31'h0, icache_hit}, {31'h0, ehit});
    check("load", icache_load, eload);
    check("imem_REN", {31'h0, imem_REN}, {31'h0, m_in_miss});
    if (m_in_miss) check("imem_addr", imem_addr, {m_miss_addr[31:2], 2'b00});
    check("perf_hits", perf_hits, m_hits);
    check("perf_misses", perf_misses, m_misses);
    if (rst) begin
      model_reset();
    end else if (m_halted) begin
    end else if (halt) begin
      m_halted  = 1;
      m_in_miss = 0;
    end else if (m_in_miss) begin
      if (!wt) begin
        ms          = set_of(m_miss_addr);
        m_valid[ms] = 1;
        m_word[ms]  = m_miss_addr[31:2];
        m_data[ms]  = ld;
        m_in_miss   = 0;
      end
    end else if (ren) begin
      if (ehit) begin
        m_hits = m_hits + 32'd1;
      end else begin
        m_misses    = m_misses + 32'd1;
        m_miss_addr = addr;
        m_in_miss   = 1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic mcycle(input logic rst, input logic ren, input logic [31:0] addr,
                        input logic halt, input logic wt);
    cycle(rst, ren, addr, halt, wt, memf({m_miss_addr[31:2], 2'b00}));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h40, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'h40, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
    tbl[2]  = '{1'b1, 32'h40, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
    tbl[3]  = '{1'b1, 32'h40, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
    tbl[4]  = '{1'b1, 32'h40, 1'b0, 32'hDEADBEEF,  1'b0, 32'h0,         1'b1, 32'h40};
    tbl[5]  = '{1'b1, 32'h40, 1'b1, 32'h0,         1'b1, 32'hDEADBEEF,  1'b0, 32'h0};
    tbl[6]  = '{1'b1, 32'h80, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[7]  = '{1'b1, 32'h80, 1'b0, 32'h11111111,  1'b0, 32'h0,         1'b1, 32'h80};
    tbl[8]  = '{1'b1, 32'h80, 1'b1, 32'h0,         1'b1, 32'h11111111,  1'b0, 32'h0};
    tbl[9]  = '{1'b1, 32'h40, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[10] = '{1'b1, 32'h40, 1'b0, 32'h22222222,  1'b0, 32'h0,         1'b1, 32'h40};
    tbl[11] = '{1'b1, 32'h40, 1'b1, 32'h0,         1'b1, 32'h22222222,  1'b0, 32'h0};

    RST = 1'b1; icache_REN = 1'b0; icache_addr = 32'h0; icache_halt = 1'b0;
    imem_wait = 1'b1; imem_load = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    #1;
    check("rst_hit", {31'h0, icache_hit}, 32'h0);
    check("rst_load", icache_load, 32'h0);
    check("rst_imem_REN", {31'h0, imem_REN}, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_perf_hits", perf_hits, 32'h0);
    check("rst_perf_misses", perf_misses, 32'h0);

    // Cold miss with a 3-cycle memory stall, then conflict eviction.
    for (int i = 0; i < 12; i++) begin
      RST = 1'b0; icache_halt = 1'b0;
      icache_REN = tbl[i].ren; icache_addr = tbl[i].addr;
      imem_wait = tbl[i].wt; imem_load = tbl[i].ld;
      #1;
      check($sformatf("tbl%0d_hit", i), {31'h0, icache_hit}, {31'h0, tbl[i].e_hit});
      check($sformatf("tbl%0d_load", i), icache_load, tbl[i].e_load);
      check($sformatf("tbl%0d_imem_REN", i), {31'h0, imem_REN}, {31'h0, tbl[i].e_imem_ren});
      if (tbl[i].e_imem_ren) check($sformatf("tbl%0d_imem_addr", i), imem_addr, tbl[i].e_imem_addr);
      cycle(1'b0, tbl[i].ren, tbl[i].addr, 1'b0, tbl[i].wt, tbl[i].ld);
      if (i == 5) begin
        check("cold_perf_hits", perf_hits, 32'd1);
        check("cold_perf_misses", perf_misses, 32'd1);
      end
    end
    check("tbl_perf_hits", perf_hits, 32'd3);
    check("tbl_perf_misses", perf_misses, 32'd3);

    // Fetch redirect while a fill is outstanding.
    mcycle(0, 1, 32'h44, 0, 1);
    mcycle(0, 1, 32'h48, 0, 1);
    mcycle(0, 1, 32'h48, 0, 0);
    mcycle(0, 1, 32'h48, 0, 1);
    check("redirect_imem_addr", imem_addr, 32'h48);
    check("redirect_imem_REN", {31'h0, imem_REN}, 32'h1);
    mcycle(0, 1, 32'h48, 0, 0);
    icache_addr = 32'h44; icache_REN = 1'b1; #1;
    check("redirect_0x44_hit", {31'h0, icache_hit}, 32'h1);
    check("redirect_0x44_load", icache_load, memf(32'h44));
    mcycle(0, 1, 32'h44, 0, 1);

    // Fill all sets, then stream hits back to back.
    for (int i = 0; i < SETS; i++) begin
      mcycle(0, 1, 32'h100 + 32'(4 * i), 0, 1);
      mcycle(0, 1, 32'h100 + 32'(4 * i), 0, ($urandom_range(0, 1) == 0));
      while (m_in_miss) mcycle(0, 1, 32'h100 + 32'(4 * i), 0, 0);
    end
    begin
      logic [31:0] h0;
      h0 = m_hits;
      for (int i = 0; i < SETS; i++) mcycle(0, 1, 32'h100 + 32'(4 * i), 0, 1);
      check("stream_perf_hits", perf_hits, h0 + 32'd16);
    end

    // Reset while memory is stalled.
    mcycle(0, 1, 32'h3C0, 0, 1);
    mcycle(0, 1, 32'h3C0, 0, 1);
    mcycle(1, 1, 32'h3C0, 0, 1);
    RST = 1'b0; icache_REN = 1'b0; #1;
    check("rstmiss_imem_REN", {31'h0, imem_REN}, 32'h0);
    check("rstmiss_perf_hits", perf_hits, 32'h0);
    check("rstmiss_perf_misses", perf_misses, 32'h0);
    icache_REN = 1'b1; icache_addr = 32'h104; #1;
    check("rstmiss_lookup", {31'h0, icache_hit}, 32'h0);
    mcycle(0, 1, 32'h104, 0, 0);
    mcycle(0, 1, 32'h104, 0, 0);

    // Halt on the same edge a fill returns.
    mcycle(1, 0, 32'h0, 0, 1);
    mcycle(0, 1, 32'h2C, 0, 1);
    mcycle(0, 1, 32'h2C, 0, 1);
    mcycle(0, 1, 32'h2C, 1, 0);
    check("halt_no_write", {31'h0, dut.valid_q[11]}, 32'h0);
    for (int i = 0; i < 6; i++) mcycle(0, 1, 32'h2C + 32'(64 * i), 0, i[0]);
    mcycle(1, 0, 32'h0, 0, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic rst, ren, halt, wt;
      logic [31:0] addr;
      rst  = ($urandom_range(0, 199) == 0) || (m_halted && ($urandom_range(0, 9) == 0));
      ren  = ($urandom_range(0, 9) < 8);
      halt = ($urandom_range(0, 149) == 0);
      wt   = ($urandom_range(0, 1) == 0);
      addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      mcycle(rst, ren, addr, halt, wt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
